match_expander: RTL and testbench
=================================

MATCH_EXPANDER -- requirements
Module: match_expander

Interface
REQ-001 SHALL have parameter HIST_ADDR_WIDTH, default 6; history depth is 2^HIST_ADDR_WIDTH bytes (64).
REQ-002 SHALL have parameter MATCH_LEN_WIDTH, default 5; match length is 0..31 bytes.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  token valid.
REQ-006 in_ready  output  1  token accepted when in_valid && in_ready.
REQ-007 in_is_match  input  1  1 = match token, 0 = literal token.
REQ-008 in_literal  input  8  literal byte; ignored for match tokens.
REQ-009 in_match_len  input  MATCH_LEN_WIDTH  match length in bytes.
REQ-010 in_offset  input  HIST_ADDR_WIDTH+1  backward distance, legal range 1..2^HIST_ADDR_WIDTH.
REQ-011 in_last  input  1  token ends the block.
REQ-012 out_valid  output  1  output byte valid, registered.
REQ-013 out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
REQ-014 out_data  output  8  reconstructed byte, registered.
REQ-015 out_last  output  1  final byte of the final token, registered.
REQ-016 busy  output  1  high in COPY state.
REQ-017 err_offset  output  1  sticky illegal-offset flag.

Function
REQ-018 Define slot_free = !out_valid || out_ready; all byte generation SHALL occur only when slot_free.
REQ-019 States SHALL be IDLE and COPY; in_ready = (state==IDLE) && slot_free.
REQ-020 IDLE, literal accepted: out_data<=in_literal, out_valid<=1, out_last<=in_last, hist[wr_ptr]<=byte, wr_ptr++, fill++ (saturating at 2^HIST_ADDR_WIDTH); latency 1 cycle; throughput 1 literal/cycle.
REQ-021 IDLE, legal match accepted (len>0, 1<=offset<=fill): latch rd_ptr=wr_ptr-offset (mod depth), remain=len, last_q=in_last; go to COPY; no byte is emitted in the accept cycle. If out_ready was high, out_valid<=0 in that cycle.
REQ-022 COPY with slot_free: out_data<=hist[rd_ptr], out_valid<=1, hist[wr_ptr]<=same byte, rd_ptr++, wr_ptr++, fill++, remain--; out_last<=last_q && remain==1; when remain==1, go to IDLE.
REQ-023 COPY without slot_free: all state holds; out_* hold stable.
REQ-024 First match byte SHALL appear on out_valid 2 cycles after the accept edge when out_ready is held high.
REQ-025 Overlapping copies (offset<len, including offset=1) SHALL replicate correctly, because each generated byte is written to history before it is next read.
REQ-026 Pointers SHALL wrap modulo 2^HIST_ADDR_WIDTH.
REQ-027 Match with len==0: token is consumed and no byte is emitted. If in_last=1, it is dropped silently.
REQ-028 Match with offset==0 or offset>fill: token is consumed, no byte is emitted, err_offset<=1, state stays IDLE.
REQ-029 err_offset SHALL clear only on rst.
REQ-030 out_valid SHALL NOT drop without a handshake; out_data SHALL NOT change while out_valid && !out_ready.

Reset
REQ-031 On rst assertion: state=IDLE, out_valid=0, out_data=0, out_last=0, busy=0, err_offset=0, wr_ptr=0, rd_ptr=0, fill=0, remain=0.
REQ-032 History contents SHALL NOT be reset.
REQ-033 Reset mid-COPY SHALL abandon the match immediately. The first post-reset match referencing pre-reset data SHALL flag err_offset.

Structure
REQ-034 Token field widths, HIST_ADDR_WIDTH and MATCH_LEN_WIDTH defaults SHALL live in the shared beezip parameter package, alongside the match-length encoder constants.
REQ-035 History storage SHALL be a sub-module match_hist_buf: one write port, one asynchronous read port, no reset.

Verification
REQ-036 Literals 0x41,0x42,0x43 back-to-back with out_ready=1 -> out_data 41,42,43 on consecutive cycles, with the first byte one cycle after accept.
REQ-037 Literal 0x5A, then match len=5 offset=1 -> out 5A,5A,5A,5A,5A,5A. busy is high for 5 cycles.
REQ-038 Literals 01,02,03, then match len=7 offset=3, in_last=1 -> out 01 02 03 01 02 03 01 02 03 01, with out_last set only on the final 01.
REQ-039 Match len=4 offset=2 while out_ready toggles 1,0,0,1,... -> bytes are correct and in order, and out_data is stable during every stall.
REQ-040 Fresh reset, then match offset=1 -> err_offset=1, no output, in_ready high next cycle. A later 70-literal stream followed by match offset=64 len=3 -> the bytes written 64 positions earlier are replayed, correct across the wrap.

Source files
------------

// File: rtl/match_expander_pkg.sv
// ---------------------------------------------------------------------------
// match_expander_pkg
// Shared beezip parameter package: token field widths, default history and
// match-length sizes, match-length encoder constants, the expander state
// type and the offset-legality helper used by the match expander.
// ---------------------------------------------------------------------------
package match_expander_pkg;

    // Default sizing of the back-reference history and of the length field.
    localparam int HIST_ADDR_WIDTH_DEF = 6;
    localparam int MATCH_LEN_WIDTH_DEF = 5;

    // Token field widths.
    localparam int LITERAL_WIDTH    = 8;
    localparam int OFFSET_WIDTH_DEF = HIST_ADDR_WIDTH_DEF + 1;

    // Match-length encoder constants shared with the compressor side.
    localparam int MIN_MATCH_LEN  = 3;
    localparam int MAX_MATCH_LEN  = (1 << MATCH_LEN_WIDTH_DEF) - 1;
    localparam int LEN_CODE_WIDTH = MATCH_LEN_WIDTH_DEF;

    // Expander control states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } exp_state_t;

    // A back-reference is legal only if it points into bytes that have
    // actually been produced since reset.
    function automatic logic offset_legal(input int unsigned offset,
                                          input int unsigned fill);
        return (offset != 32'd0) && (offset <= fill);
    endfunction

endpackage

// File: rtl/match_hist_buf.sv
// ---------------------------------------------------------------------------
// match_hist_buf
// History storage for the match expander: 2^ADDR_WIDTH bytes, one
// synchronous write port, one asynchronous read port, no reset (contents
// survive reset by design).
//   clk      : write clock, rising edge
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data (combinational from rd_addr)
// ---------------------------------------------------------------------------
module match_hist_buf
    import match_expander_pkg::*;
#(
    parameter int ADDR_WIDTH = HIST_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = LITERAL_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Byte write into the history ring.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/match_expander.sv
// ---------------------------------------------------------------------------
// match_expander
// Expands a stream of literal / match tokens into bytes. Literals pass
// through with one cycle of latency; matches replay bytes from a sliding
// history window, one byte per cycle, including overlapping copies.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   in_valid/ready: token handshake
//   in_is_match   : 1 = match token, 0 = literal token
//   in_literal    : literal byte
//   in_match_len  : match length in bytes
//   in_offset     : backward distance, legal 1..2^HIST_ADDR_WIDTH
//   in_last       : token ends the block
//   out_valid/ready, out_data, out_last : registered byte output
//   busy          : high while a match is being copied
//   err_offset    : sticky illegal-offset flag, cleared only by rst
// ---------------------------------------------------------------------------
module match_expander
    import match_expander_pkg::*;
#(
    parameter int HIST_ADDR_WIDTH = HIST_ADDR_WIDTH_DEF,
    parameter int MATCH_LEN_WIDTH = MATCH_LEN_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_match,
    input  logic [LITERAL_WIDTH-1:0]   in_literal,
    input  logic [MATCH_LEN_WIDTH-1:0] in_match_len,
    input  logic [HIST_ADDR_WIDTH:0]   in_offset,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LITERAL_WIDTH-1:0]   out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       err_offset
);

    localparam logic [HIST_ADDR_WIDTH:0]   FILL_MAX = {1'b1, {HIST_ADDR_WIDTH{1'b0}}};
    localparam logic [HIST_ADDR_WIDTH:0]   FILL_ONE = {{HIST_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [HIST_ADDR_WIDTH-1:0] PTR_ONE  = {{(HIST_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MATCH_LEN_WIDTH-1:0] LEN_ONE  = {{(MATCH_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MATCH_LEN_WIDTH-1:0] LEN_ZERO = {MATCH_LEN_WIDTH{1'b0}};

    exp_state_t                 state, state_nxt;
    logic                       out_valid_nxt, out_last_nxt, err_nxt;
    logic [LITERAL_WIDTH-1:0]   out_data_nxt;
    logic [HIST_ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [HIST_ADDR_WIDTH:0]   fill, fill_nxt, fill_inc;
    logic [MATCH_LEN_WIDTH-1:0] remain, remain_nxt;
    logic                       last_q, last_q_nxt;
    logic                       slot_free;
    logic                       hist_we;
    logic [LITERAL_WIDTH-1:0]   hist_wdata, hist_rdata;

    // The output register can take a new byte when it is empty or being drained.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == ST_IDLE) && slot_free;
    assign busy      = (state == ST_COPY);
    // fill counts valid history bytes and saturates at the window size.
    assign fill_inc  = (fill == FILL_MAX) ? fill : (fill + FILL_ONE);

    match_hist_buf #(
        .ADDR_WIDTH (HIST_ADDR_WIDTH),
        .DATA_WIDTH (LITERAL_WIDTH)
    ) u_hist (
        .clk     (clk),
        .wr_en   (hist_we),
        .wr_addr (wr_ptr),
        .wr_data (hist_wdata),
        .rd_addr (rd_ptr),
        .rd_data (hist_rdata)
    );

    // Next-state and datapath decode; nothing moves unless the output slot is free.
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
        err_nxt       = err_offset;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        fill_nxt      = fill;
        remain_nxt    = remain;
        last_q_nxt    = last_q;
        hist_we       = 1'b0;
        hist_wdata    = hist_rdata;
        if (slot_free) begin
            // Any held byte has been taken; only a newly generated byte re-arms valid.
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!in_valid) begin
                        state_nxt = ST_IDLE;
                    end else if (!in_is_match) begin
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = in_literal;
                        out_last_nxt  = in_last;
                        hist_we       = 1'b1;
                        hist_wdata    = in_literal;
                        wr_ptr_nxt    = wr_ptr + PTR_ONE;
                        fill_nxt      = fill_inc;
                    end else if (!offset_legal(32'(in_offset), 32'(fill))) begin
                        err_nxt = 1'b1;
                    end else if (in_match_len == LEN_ZERO) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        // Offset equal to the window size wraps onto wr_ptr itself,
                        // which still holds the byte written one window ago.
                        rd_ptr_nxt = wr_ptr - in_offset[HIST_ADDR_WIDTH-1:0];
                        remain_nxt = in_match_len;
                        last_q_nxt = in_last;
                        state_nxt  = ST_COPY;
                    end
                end
                ST_COPY: begin
                    // The copied byte is written back so overlapping copies see it.
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = hist_rdata;
                    out_last_nxt  = last_q && (remain == LEN_ONE);
                    hist_we       = 1'b1;
                    hist_wdata    = hist_rdata;
                    rd_ptr_nxt    = rd_ptr + PTR_ONE;
                    wr_ptr_nxt    = wr_ptr + PTR_ONE;
                    fill_nxt      = fill_inc;
                    remain_nxt    = remain - LEN_ONE;
                    if (remain == LEN_ONE) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_COPY;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt = state;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= {LITERAL_WIDTH{1'b0}};
            out_last   <= 1'b0;
            err_offset <= 1'b0;
            wr_ptr     <= {HIST_ADDR_WIDTH{1'b0}};
            rd_ptr     <= {HIST_ADDR_WIDTH{1'b0}};
            fill       <= {(HIST_ADDR_WIDTH+1){1'b0}};
            remain     <= {MATCH_LEN_WIDTH{1'b0}};
            last_q     <= 1'b0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_last   <= out_last_nxt;
            err_offset <= err_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fill       <= fill_nxt;
            remain     <= remain_nxt;
            last_q     <= last_q_nxt;
        end
    end

endmodule

// File: tb/tb_match_expander.sv
// ---------------------------------------------------------------------------
// tb_match_expander
// Self-checking bench for match_expander. A byte-stream model (every byte
// produced since reset, in order) predicts each output byte; a negedge
// monitor compares the DUT against it, and directed scenarios pin the model
// with hand-computed byte sequences.
// ---------------------------------------------------------------------------
module tb_match_expander;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } ob_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_is_match = 1'b0;
    logic [7:0] in_literal = 8'h00;
    logic [4:0] in_match_len = 5'd0;
    logic [6:0] in_offset = 7'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       err_offset;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    ob_t  exp_q[$];
    logic [7:0] hist_m[$];
    logic exp_err = 1'b0;
    ob_t  log_q[$];
    int   log_cyc[$];
    int   busy_cnt = 0;
    int   stall_cnt = 0;
    int   last_acc_cyc = 0;
    int   rdy_mode = 0;
    int   pat_idx = 0;
    logic stall_prev = 1'b0;
    ob_t  stall_val;

    match_expander dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_match  (in_is_match),
        .in_literal   (in_literal),
        .in_match_len (in_match_len),
        .in_offset    (in_offset),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .err_offset   (err_offset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Advance one clock and pick out_ready for the coming cycle.
    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                out_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                pat_idx++;
            end
        endcase
    endtask

    // Reference behaviour: the output is the running byte stream itself.
    task automatic model_accept(input logic is_m, input logic [7:0] lit,
                                input int len, input int off, input logic last);
        int   fillm;
        logic [7:0] b;
        last_acc_cyc = cyc;
        if (!is_m) begin
            hist_m.push_back(lit);
            exp_q.push_back('{last: last, data: lit});
        end else begin
            fillm = (hist_m.size() > 64) ? 64 : hist_m.size();
            if (off == 0 || off > fillm) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 0; i < len; i++) begin
                    b = hist_m[hist_m.size() - off];
                    hist_m.push_back(b);
                    exp_q.push_back('{last: (last && i == len - 1), data: b});
                end
            end
        end
    endtask

    task automatic send(input logic is_m, input logic [7:0] lit, input int len,
                        input int off, input logic last);
        logic acc;
        int   waitc;
        acc = 1'b0;
        waitc = 0;
        in_valid     = 1'b1;
        in_is_match  = is_m;
        in_literal   = lit;
        in_match_len = len[4:0];
        in_offset    = off[6:0];
        in_last      = last;
        while (!acc && waitc < 200) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) model_accept(is_m, lit, len, off, last);
            waitc++;
        end
        check("send_accepted", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        hist_m.delete();
        exp_err = 1'b0;
        step();
        step();
        rst = 1'b0;
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 800) begin
            step();
            n++;
        end
        check("drain_in_time", int'(n < 800), 1);
        step();
    endtask

    task automatic check_log(input string name, input logic [7:0] want[$],
                             input logic last_on_final);
        check({name, "_count"}, log_q.size(), want.size());
        for (int i = 0; i < want.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), int'(log_q[i].data), int'(want[i]));
            check($sformatf("%s_last%0d", name, i), int'(log_q[i].last),
                  int'(last_on_final && (i == want.size() - 1)));
        end
    endtask

    // Monitor: checks every handshaked byte, stall stability and the error flag.
    always @(negedge clk) begin : monitor
        ob_t e;
        if (!rst) begin
            if (stall_prev) begin
                stall_cnt++;
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(stall_val.data));
                check("stall_last_held", int'(out_last), int'(stall_val.last));
            end
            check("err_offset", int'(err_offset), int'(exp_err));
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                check("byte_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", int'(out_data), int'(e.data));
                    check("out_last", int'(out_last), int'(e.last));
                end
                log_q.push_back('{last: out_last, data: out_data});
                log_cyc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = '{last: out_last, data: out_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] w[$];
        int first_acc;
        int macc;
        int fillm;
        int len;
        int off;

        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_offset), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Back-to-back literals, one cycle latency.
        rdy_mode = 0;
        send(1'b0, 8'h41, 0, 0, 1'b0);
        first_acc = last_acc_cyc;
        send(1'b0, 8'h42, 0, 0, 1'b0);
        send(1'b0, 8'h43, 0, 0, 1'b0);
        drain();
        w = '{8'h41, 8'h42, 8'h43};
        check_log("lit3", w, 1'b0);
        if (log_cyc.size() == 3) begin
            check("lit3_latency", log_cyc[0], first_acc);
            check("lit3_b1_cycle", log_cyc[1], first_acc + 1);
            check("lit3_b2_cycle", log_cyc[2], first_acc + 2);
        end

        // Run-length: offset 1 replicates the previous byte.
        log_q.delete(); log_cyc.delete();
        busy_cnt = 0;
        send(1'b0, 8'h5A, 0, 0, 1'b0);
        send(1'b1, 8'h00, 5, 1, 1'b0);
        macc = last_acc_cyc;
        drain();
        w = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        check_log("rle", w, 1'b0);
        check("rle_busy_cycles", busy_cnt, 5);
        if (log_cyc.size() >= 2) check("match_latency", log_cyc[1], macc + 1);

        // Overlapping copy with last flag on the final byte only.
        log_q.delete(); log_cyc.delete();
        send(1'b0, 8'h01, 0, 0, 1'b0);
        send(1'b0, 8'h02, 0, 0, 1'b0);
        send(1'b0, 8'h03, 0, 0, 1'b0);
        send(1'b1, 8'h00, 7, 3, 1'b1);
        drain();
        w = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h01};
        check_log("ovl", w, 1'b1);

        // Match under out_ready pattern 1,0,0,1,...
        log_q.delete(); log_cyc.delete();
        rdy_mode = 2; pat_idx = 0; stall_cnt = 0;
        send(1'b0, 8'h11, 0, 0, 1'b0);
        send(1'b0, 8'h22, 0, 0, 1'b0);
        send(1'b1, 8'h00, 4, 2, 1'b0);
        drain();
        w = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
        check_log("stall", w, 1'b0);
        check("stall_seen", int'(stall_cnt > 0), 1);

        // Fresh reset: any back-reference is illegal; then a full-window replay.
        rdy_mode = 0;
        do_reset();
        send(1'b1, 8'h00, 3, 1, 1'b0);
        check("err_after_bad_offset", int'(err_offset), 1);
        check("no_out_after_bad_offset", int'(out_valid), 0);
        check("in_ready_after_bad_offset", int'(in_ready), 1);
        for (int i = 0; i < 70; i++) send(1'b0, 8'(i), 0, 0, 1'b0);
        drain();
        log_q.delete(); log_cyc.delete();
        send(1'b1, 8'h00, 3, 64, 1'b1);
        drain();
        w = '{8'h06, 8'h07, 8'h08};
        check_log("wrap64", w, 1'b1);
        check("err_sticky", int'(err_offset), 1);

        // Reset in the middle of a copy abandons it and forgets history.
        do_reset();
        send(1'b0, 8'hAA, 0, 0, 1'b0);
        send(1'b1, 8'h00, 20, 1, 1'b0);
        step(); step(); step();
        check("busy_mid_copy", int'(busy), 1);
        do_reset();
        check("busy_after_rst", int'(busy), 0);
        check("valid_after_rst", int'(out_valid), 0);
        send(1'b1, 8'h00, 2, 1, 1'b0);
        drain();
        check("err_stale_ref", int'(err_offset), 1);
        check("stale_ref_no_bytes", log_q.size(), 0);

        // Randomized token stream against the model.
        do_reset();
        rdy_mode = 1;
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 2)) step();
            fillm = (hist_m.size() > 64) ? 64 : hist_m.size();
            if ($urandom_range(0, 1) == 0 || fillm == 0 && $urandom_range(0, 3) != 0) begin
                send(1'b0, 8'($urandom_range(0, 255)), 0, 0, ($urandom_range(0, 7) == 0));
            end else begin
                len = $urandom_range(0, 31);
                if (fillm > 0 && $urandom_range(0, 9) != 0) begin
                    off = $urandom_range(1, fillm);
                end else begin
                    off = (fillm < 64 && $urandom_range(0, 1) == 1) ? $urandom_range(fillm + 1, 64) : 0;
                    if (len == 0) len = $urandom_range(1, 31);
                end
                send(1'b1, 8'h00, len, off, ($urandom_range(0, 7) == 0));
            end
        end
        drain();
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_idle_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
